// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the head of IF: exception, pending redirect, JR, jump, branch, sequential.
// Optional return-address stack enabled by defining RAS_EN.
module pc_sequencer #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h8000_0180),
    parameter int              RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              bne_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] imm_i,
    input  logic              jump_i,
    input  logic              link_i,
    input  logic [25:0]       instr26_i,
    input  logic              jr_i,
    input  logic              ret_i,
    input  logic [ADDR_W-1:0] rs_val_i,
    input  logic              exc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              pc_valid_o,
    output logic              redirect_o,
    output logic              misalign_o,
    output logic              ras_empty_o
);

    localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] pc_r;
    logic              pc_valid_r;
    logic              redirect_r;
    logic              misalign_r;
    logic              pend_valid_r;
    logic [ADDR_W-1:0] pend_tgt_r;
    logic              pend_mis_r;

    logic [ADDR_W-1:0] pc_plus4_s;
    logic              br_tk_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic [ADDR_W-1:0] jmp_tgt_s;
    logic [ADDR_W-1:0] jr_raw_s;
    logic              jr_mis_s;
    logic [ADDR_W-1:0] jr_tgt_s;
    logic              req_s;
    logic [ADDR_W-1:0] req_tgt_s;
    logic              req_mis_s;
    logic              ras_hit_s;
    logic              push_s;
    logic              pop_s;

    logic [ADDR_W-1:0] pc_nxt_s;
    logic              redirect_nxt_s;
    logic              misalign_nxt_s;
    logic              pend_valid_nxt_s;
    logic [ADDR_W-1:0] pend_tgt_nxt_s;
    logic              pend_mis_nxt_s;

    assign pc_plus4_s = pc_r + ADDR_W'(4);
    assign br_tk_s    = branch_i & (zero_i ^ bne_i);
    assign br_tgt_s   = pc_plus4_s + (imm_i << 2);
    assign jmp_tgt_s  = (pc_plus4_s & ~LOW28_MASK) | ADDR_W'({instr26_i, 2'b00});

`ifdef RAS_EN
    localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_r [RAS_DEPTH];
    logic [SP_W-1:0]   ras_sp_r;
    logic [CNT_W-1:0]  ras_cnt_r;
    logic [SP_W-1:0]   ras_top_idx_s;

    assign ras_top_idx_s = ras_sp_r - SP_W'(1);
    assign ras_empty_o   = (ras_cnt_r == CNT_W'(0));
    assign ras_hit_s     = ret_i & ~ras_empty_o;
    assign jr_raw_s      = ras_hit_s ? ras_r[ras_top_idx_s] : rs_val_i;
`else
    assign ras_empty_o = 1'b1;
    assign ras_hit_s   = 1'b0;
    assign jr_raw_s    = rs_val_i;
`endif

    assign jr_mis_s = (jr_raw_s[1:0] != 2'b00);
    assign jr_tgt_s = jr_mis_s ? EXC_VEC : jr_raw_s;

    // Select the highest-priority redirect request among JR, jump and taken branch
    always_comb begin
        req_s     = 1'b0;
        req_tgt_s = pc_plus4_s;
        req_mis_s = 1'b0;
        if (jr_i) begin
            req_s     = 1'b1;
            req_tgt_s = jr_tgt_s;
            req_mis_s = jr_mis_s;
        end else if (jump_i) begin
            req_s     = 1'b1;
            req_tgt_s = jmp_tgt_s;
        end else if (br_tk_s) begin
            req_s     = 1'b1;
            req_tgt_s = br_tgt_s;
        end else begin
            req_s     = 1'b0;
        end
    end

    // Push only for a JAL actually loaded; a return pops whenever its JR is taken (applied or latched)
    assign push_s = jump_i & link_i & ~jr_i & ~exc_i & ~stall_i & ~pend_valid_r;
    assign pop_s  = jr_i & ras_hit_s & ~exc_i & ~pend_valid_r;

    // Next-state selection for PC, flush/misalign pulses and the pending-redirect latch
    always_comb begin
        pc_nxt_s         = pc_r;
        redirect_nxt_s   = 1'b0;
        misalign_nxt_s   = 1'b0;
        pend_valid_nxt_s = pend_valid_r;
        pend_tgt_nxt_s   = pend_tgt_r;
        pend_mis_nxt_s   = pend_mis_r;
        if (exc_i) begin
            pc_nxt_s         = EXC_VEC;
            redirect_nxt_s   = 1'b1;
            pend_valid_nxt_s = 1'b0;
            pend_mis_nxt_s   = 1'b0;
        end else if (stall_i) begin
            if (!pend_valid_r && req_s) begin
                pend_valid_nxt_s = 1'b1;
                pend_tgt_nxt_s   = req_tgt_s;
                pend_mis_nxt_s   = req_mis_s;
            end else begin
                pend_valid_nxt_s = pend_valid_r;
            end
        end else if (pend_valid_r) begin
            pc_nxt_s         = pend_tgt_r;
            redirect_nxt_s   = 1'b1;
            misalign_nxt_s   = pend_mis_r;
            pend_valid_nxt_s = 1'b0;
            pend_mis_nxt_s   = 1'b0;
        end else if (req_s) begin
            pc_nxt_s       = req_tgt_s;
            redirect_nxt_s = 1'b1;
            misalign_nxt_s = req_mis_s;
        end else begin
            pc_nxt_s = pc_plus4_s;
        end
    end

    // PC, output pulses and pending latch registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r         <= RESET_VEC;
            pc_valid_r   <= 1'b0;
            redirect_r   <= 1'b0;
            misalign_r   <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_tgt_r   <= '0;
            pend_mis_r   <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            pc_valid_r   <= 1'b1;
            redirect_r   <= redirect_nxt_s;
            misalign_r   <= misalign_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_tgt_r   <= pend_tgt_nxt_s;
            pend_mis_r   <= pend_mis_nxt_s;
        end
    end

`ifdef RAS_EN
    // Circular return-address stack; a push when full overwrites the oldest slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= '0;
            end
            ras_sp_r  <= '0;
            ras_cnt_r <= '0;
        end else if (push_s) begin
            ras_r[ras_sp_r] <= pc_plus4_s;
            ras_sp_r        <= ras_sp_r + SP_W'(1);
            if (ras_cnt_r != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_r <= ras_cnt_r + CNT_W'(1);
            end else begin
                ras_cnt_r <= ras_cnt_r;
            end
        end else if (pop_s) begin
            ras_sp_r  <= ras_top_idx_s;
            ras_cnt_r <= ras_cnt_r - CNT_W'(1);
        end else begin
            ras_sp_r  <= ras_sp_r;
            ras_cnt_r <= ras_cnt_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = ret_i ^ link_i ^ push_s ^ pop_s;
`endif

    assign pc_o       = pc_r;
    assign pc_plus4_o = pc_plus4_s;
    assign pc_valid_o = pc_valid_r;
    assign redirect_o = redirect_r;
    assign misalign_o = misalign_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; return-stack steps compile in when RAS_EN is defined.
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0, branch_i = 1'b0, bne_i = 1'b0, zero_i = 1'b0;
    logic [31:0] imm_i = 32'd0;
    logic        jump_i = 1'b0, link_i = 1'b0;
    logic [25:0] instr26_i = 26'd0;
    logic        jr_i = 1'b0, ret_i = 1'b0;
    logic [31:0] rs_val_i = 32'd0;
    logic        exc_i = 1'b0;
    logic [31:0] pc_o, pc_plus4_o;
    logic        pc_valid_o, redirect_o, misalign_o, ras_empty_o;

    int compared = 0;
    int mismatched = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .branch_i(branch_i), .bne_i(bne_i),
        .zero_i(zero_i), .imm_i(imm_i), .jump_i(jump_i), .link_i(link_i), .instr26_i(instr26_i),
        .jr_i(jr_i), .ret_i(ret_i), .rs_val_i(rs_val_i), .exc_i(exc_i), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .pc_valid_o(pc_valid_o), .redirect_o(redirect_o),
        .misalign_o(misalign_o), .ras_empty_o(ras_empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        branch_i = 1'b0; bne_i = 1'b0; zero_i = 1'b0; jump_i = 1'b0; link_i = 1'b0;
        jr_i = 1'b0; ret_i = 1'b0; exc_i = 1'b0;
    endtask

    task automatic go_jr(input logic [31:0] tgt);
        clear_req();
        jr_i = 1'b1; rs_val_i = tgt;
        step();
        jr_i = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_pc", pc_o, 32'h0);
        check("rst_valid", 32'(pc_valid_o), 32'd0);
        check("rst_redirect", 32'(redirect_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_ras_empty", 32'(ras_empty_o), 32'd1);
        check("rst_plus4", pc_plus4_o, 32'h4);
        #10 reset = 1'b1;

        step();
        check("seq1_pc", pc_o, 32'h4);
        check("seq1_valid", 32'(pc_valid_o), 32'd1);
        check("seq1_redirect", 32'(redirect_o), 32'd0);
        step();
        check("seq2_pc", pc_o, 32'h8);

        // Branch equal, taken with negative offset
        go_jr(32'h100);
        check("jr100_pc", pc_o, 32'h100);
        check("jr100_redirect", 32'(redirect_o), 32'd1);
        branch_i = 1'b1; zero_i = 1'b1; imm_i = 32'hFFFF_FFFE;
        step();
        check("beq_tk_pc", pc_o, 32'hFC);
        check("beq_tk_redirect", 32'(redirect_o), 32'd1);
        go_jr(32'h100);
        branch_i = 1'b1; zero_i = 1'b0;
        step();
        check("beq_nt_pc", pc_o, 32'h104);
        check("beq_nt_redirect", 32'(redirect_o), 32'd0);
        bne_i = 1'b1;
        step();
        check("bne_tk_pc", pc_o, 32'h100);
        clear_req();

        // Jump, then jump versus JR in the same cycle
        go_jr(32'h1000_0040);
        jump_i = 1'b1; instr26_i = 26'h0000123;
        step();
        check("jump_pc", pc_o, 32'h1000_048C);
        check("jump_redirect", 32'(redirect_o), 32'd1);
        go_jr(32'h1000_0040);
        jump_i = 1'b1; jr_i = 1'b1; rs_val_i = 32'h2000;
        step();
        check("jr_over_jump_pc", pc_o, 32'h2000);
        clear_req();
        step();
        check("after_jr_redirect", 32'(redirect_o), 32'd0);
        go_jr(32'h2000);

        // Stall with a jump latched; a later JR during the stall is ignored
        stall_i = 1'b1; jump_i = 1'b1; instr26_i = 26'h0000100;
        step();
        check("stall1_pc", pc_o, 32'h2000);
        check("stall1_redirect", 32'(redirect_o), 32'd0);
        jump_i = 1'b0; jr_i = 1'b1; rs_val_i = 32'h3000;
        step();
        check("stall2_pc", pc_o, 32'h2000);
        jr_i = 1'b0;
        step();
        check("stall3_pc", pc_o, 32'h2000);
        check("stall3_redirect", 32'(redirect_o), 32'd0);
        stall_i = 1'b0;
        step();
        check("release_pc", pc_o, 32'h400);
        check("release_redirect", 32'(redirect_o), 32'd1);
        step();
        check("post_release_pc", pc_o, 32'h404);
        check("post_release_redirect", 32'(redirect_o), 32'd0);

        // Misaligned JR
        go_jr(32'h2002);
        check("mis_pc", pc_o, EXC);
        check("mis_flag", 32'(misalign_o), 32'd1);
        check("mis_redirect", 32'(redirect_o), 32'd1);
        step();
        check("mis_clear", 32'(misalign_o), 32'd0);
        check("mis_next_pc", pc_o, EXC + 32'd4);

        // Exception during stall clears the pending latch
        stall_i = 1'b1; jump_i = 1'b1; instr26_i = 26'h0000100;
        step();
        check("exc_stall_hold", pc_o, EXC + 32'd4);
        jump_i = 1'b0; exc_i = 1'b1;
        step();
        check("exc_pc", pc_o, EXC);
        check("exc_redirect", 32'(redirect_o), 32'd1);
        exc_i = 1'b0;
        step();
        check("exc_hold_pc", pc_o, EXC);
        check("exc_hold_redirect", 32'(redirect_o), 32'd0);
        stall_i = 1'b0;
        step();
        check("exc_no_pend_pc", pc_o, EXC + 32'd4);
        check("exc_no_pend_redirect", 32'(redirect_o), 32'd0);

        // Reset while a redirect is pending
        stall_i = 1'b1; jump_i = 1'b1;
        step();
        jump_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_valid", 32'(pc_valid_o), 32'd0);
        #3 reset = 1'b1;
        stall_i = 1'b0;
        step();
        check("midrst_after_pc", pc_o, 32'h4);
        check("midrst_after_redirect", 32'(redirect_o), 32'd0);

`ifdef RAS_EN
        // Five JALs into a four-entry stack, then five returns
        go_jr(32'h10);
        jump_i = 1'b1; link_i = 1'b1;
        instr26_i = 26'h8;  step();
        check("jal1_pc", pc_o, 32'h20);
        check("jal1_nonempty", 32'(ras_empty_o), 32'd0);
        instr26_i = 26'hC;  step();
        instr26_i = 26'h10; step();
        instr26_i = 26'h14; step();
        check("jal4_pc", pc_o, 32'h50);
        instr26_i = 26'h40; step();
        check("jal5_pc", pc_o, 32'h100);
        clear_req();
        jr_i = 1'b1; ret_i = 1'b1; rs_val_i = 32'h3000;
        step();
        check("ret1_pc", pc_o, 32'h54);
        step();
        check("ret2_pc", pc_o, 32'h44);
        step();
        check("ret3_pc", pc_o, 32'h34);
        check("ret3_nonempty", 32'(ras_empty_o), 32'd0);
        step();
        check("ret4_pc", pc_o, 32'h24);
        check("ret4_empty", 32'(ras_empty_o), 32'd1);
        step();
        check("ret5_pc", pc_o, 32'h3000);
        clear_req();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
